// File: rtl/fifo_stage_pkg.sv
// Shared pipeline definitions: operand width, default buffer depth and ALU opcodes.
package fifo_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for fifo_stage: one write port and one asynchronous read port.
module fifo_mem
    import fifo_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are meaningless until written, so the array carries no reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_stage.sv
// Elastic operand buffer in front of an ALU input, using the valid/stall handshake on both sides.
module fifo_stage
    import fifo_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             stall_o,
    output logic             v_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             stall_i,
    output logic [AW:0]      count_o
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rdata;

    // Handshake outputs depend only on registered occupancy, never on stall_i or v_i.
    assign stall_o = (count_q == (AW+1)'(DEPTH));
    assign v_o     = (count_q != '0);
    assign count_o = count_q;
    assign data_o  = v_o ? rdata : '0;

    assign push = v_i & ~stall_o & ~flush_i;
    assign pop  = v_o & ~stall_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_i),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fifo_stage.sv
// Directed bench for fifo_stage with a queue-based reference of the buffer contents.
module tb_fifo_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        v_i;
    logic [31:0] data_i;
    logic        stall_o;
    logic        v_o;
    logic [31:0] data_o;
    logic        stall_i;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    fifo_stage #(
        .WIDTH (32),
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .stall_o (stall_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .stall_i (stall_i),
        .count_o (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference, then advance the reference by one edge.
    task automatic cycle(input logic vi, input logic [31:0] di, input logic si, input logic fl);
        int sz;
        logic [31:0] head;
        v_i = vi; data_i = di; stall_i = si; flush_i = fl;
        @(negedge clk);
        sz   = sb_q.size();
        head = (sz != 0) ? sb_q[0] : 32'h0;
        chk("count_o", {29'b0, count_o}, sz);
        chk("v_o",     {31'b0, v_o},     {31'b0, (sz != 0)});
        chk("stall_o", {31'b0, stall_o}, {31'b0, (sz == 4)});
        chk("data_o",  data_o,           head);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (sz != 0 && !si) void'(sb_q.pop_front());
            if (vi && sz != 4) sb_q.push_back(di);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; v_i = 1'b0; data_i = '0; stall_i = 1'b0;
        #1;
        chk("rst_v_o",     {31'b0, v_o},     32'h0);
        chk("rst_stall_o", {31'b0, stall_o}, 32'h0);
        chk("rst_count_o", {29'b0, count_o}, 32'h0);
        chk("rst_data_o",  data_o,           32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single word into an empty buffer appears only after its edge.
        cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Fill to four under back-pressure, hold a fifth, then drain in order.
        cycle(1'b1, 32'h11, 1'b1, 1'b0);
        cycle(1'b1, 32'h22, 1'b1, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        cycle(1'b1, 32'h44, 1'b1, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Steady state at two entries with simultaneous push and pop; pointers wrap.
        cycle(1'b1, 32'hA0, 1'b1, 1'b0);
        cycle(1'b1, 32'hA1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'hB0 + i, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Flush at three entries discards the word offered that cycle.
        cycle(1'b1, 32'hC0, 1'b1, 1'b0);
        cycle(1'b1, 32'hC1, 1'b1, 1'b0);
        cycle(1'b1, 32'hC2, 1'b1, 1'b0);
        cycle(1'b1, 32'hC3, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'hD0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset with three entries clears outputs before the next edge.
        cycle(1'b1, 32'hE0, 1'b1, 1'b0);
        cycle(1'b1, 32'hE1, 1'b1, 1'b0);
        cycle(1'b1, 32'hE2, 1'b1, 1'b0);
        v_i = 1'b0; stall_i = 1'b1;
        chk("pre_rst_count_o", {29'b0, count_o}, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_v_o",     {31'b0, v_o},     32'h0);
        chk("async_rst_stall_o", {31'b0, stall_o}, 32'h0);
        chk("async_rst_count_o", {29'b0, count_o}, 32'h0);
        chk("async_rst_data_o",  data_o,           32'h0);
        sb_q.delete();
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'hF0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
